sr_count_ctrl: RTL and testbench

Sequencing controller for an external W-bit bank of SR flip-flops used as a counter. It drives per-bit set/reset excitation so that the bank loads a start value, then steps up or down on each qualified tick until it reaches a programmed limit. It handshakes with a requester through start/busy/done. It sits beside the SR-flip-flop counter datapath, replacing hard-wired excitation gates with a programmable sequence.

---
 rtl/sr_count_ctrl.sv | 165 ++++++++++++++++
 tb/tb_sr_count_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_count_ctrl.sv
// ---------------------------------------------------------------------------
// sr_count_ctrl
//
// Sequencing controller for an external W-bit bank of SR flip-flops used as
// a counter. On an accepted start the bank is loaded with a start value and
// then steps up or down on each qualified tick until it reaches the limit.
// The set/reset excitation is decoded from a target value T as
// s = T & ~q and r = ~T & q, so s & r is always zero.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset
//   start     request, sampled only in IDLE
//   dir       0 = count up, 1 = count down (captured with start)
//   load_val  initial bank value (captured with start)
//   limit     terminal value (captured with start)
//   tick      step qualifier while running
//   q         present bank outputs (feedback)
//   s, r      per-bit set / reset excitation to the bank
//   busy      high in LOAD and RUN
//   done      one-cycle completion pulse
//   err       sticky mismatch flag
//
// Optional feature: define SR_COUNT_CTRL_VERIFY_EN to build a shadow register
// that tracks the expected bank value. A divergence between q and the shadow
// sets err and ends the run. Without the macro err is constant 0.
// ---------------------------------------------------------------------------
module sr_count_ctrl #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         dir,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] limit,
    input  logic         tick,
    input  logic [W-1:0] q,
    output logic [W-1:0] s,
    output logic [W-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         err
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        RUN  = 2'b10,
        DONE = 2'b11
    } state_t;

    state_t       state;
    state_t       state_next;
    logic         dir_reg;
    logic [W-1:0] load_reg;
    logic [W-1:0] limit_reg;
    logic         accept;
    logic         at_limit;
    logic         mismatch;
    logic         drive;
    logic [W-1:0] target;

    assign accept   = (state == IDLE) && start;
    assign at_limit = (q == limit_reg);

`ifdef SR_COUNT_CTRL_VERIFY_EN
    // Shadow of the value the bank should hold after each excitation.
    logic [W-1:0] exp_reg;
    logic         err_reg;
    logic         step;

    assign mismatch = (state == RUN) && (q != exp_reg);
    assign step     = (state == RUN) && !at_limit && !mismatch && tick;
    assign err      = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_reg <= '0;
            err_reg <= 1'b0;
        end else begin
            if (state == LOAD) begin
                exp_reg <= load_reg;
            end else if (step) begin
                exp_reg <= target;
            end

            if (accept) begin
                err_reg <= 1'b0;
            end else if (mismatch) begin
                err_reg <= 1'b1;
            end
        end
    end
`else
    assign mismatch = 1'b0;
    assign err      = 1'b0;
`endif

    // State and capture registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state     <= IDLE;
            dir_reg   <= 1'b0;
            load_reg  <= '0;
            limit_reg <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                dir_reg   <= dir;
                load_reg  <= load_val;
                limit_reg <= limit;
            end
        end
    end

    // Next state, target selection and handshake outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        drive      = 1'b0;
        target     = q;
        busy       = 1'b0;
        done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                busy       = 1'b1;
                drive      = 1'b1;
                target     = load_reg;
                state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                // Reaching the limit (or a bank divergence) wins over tick.
                if (at_limit || mismatch) begin
                    state_next = DONE;
                end else if (tick) begin
                    drive  = 1'b1;
                    target = dir_reg ? (q - W'(1)) : (q + W'(1));
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Excitation only moves bits that differ from the target.
    assign s = drive ? (target & ~q) : '0;
    assign r = drive ? (~target & q) : '0;

endmodule

// File: tb/tb_sr_count_ctrl.sv
module tb_sr_count_ctrl;

    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         dir;
    logic [W-1:0] load_val;
    logic [W-1:0] limit;
    logic         tick;
    logic [W-1:0] q;
    logic [W-1:0] s;
    logic [W-1:0] r;
    logic         busy;
    logic         done;
    logic         err;

    int total = 0;
    int bad   = 0;

    // SR bank model; stuck_zero forces selected bits to 0.
    logic [W-1:0] bank = '0;
    logic [W-1:0] stuck_zero = '0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bank <= ((bank & ~r) | s) & ~stuck_zero;
    end

    assign q = bank;

    sr_count_ctrl #(.W(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dir      (dir),
        .load_val (load_val),
        .limit    (limit),
        .tick     (tick),
        .q        (q),
        .s        (s),
        .r        (r),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    typedef struct {
        logic [W-1:0] load;
        logic [W-1:0] lim;
        logic         dn;
        int           done_edge;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Advance one edge and sample 1 time unit later; s/r exclusivity always.
    task automatic step();
        @(posedge clk);
        #1;
        check("sr_exclusive", 32'(s & r), 32'd0);
`ifndef SR_COUNT_CTRL_VERIFY_EN
        check("err_tied_low", 32'(err), 32'd0);
`endif
    endtask

    // Issue start (edge 0) with the given operands; leaves start low after.
    task automatic kick(input logic [W-1:0] ld, input logic [W-1:0] lm, input logic dn);
        load_val = ld;
        limit    = lm;
        dir      = dn;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    // Run a transaction with tick held high; checks busy on every edge,
    // the done edge and the final bank value.
    task automatic run_vec(input vec_t v, input int idx);
        int got_edge;
        got_edge = -1;
        tick = 1'b1;
        kick(v.load, v.lim, v.dn);
        check($sformatf("v%0d_busy_e0", idx), 32'(busy), 32'd1);
        for (int e = 1; e < 20; e++) begin
            step();
            if (done) begin
                got_edge = e;
                break;
            end
            check($sformatf("v%0d_busy_e%0d", idx, e), 32'(busy), 32'd1);
        end
        check($sformatf("v%0d_done_edge", idx), 32'(got_edge), 32'(v.done_edge));
        check($sformatf("v%0d_busy_at_done", idx), 32'(busy), 32'd0);
        check($sformatf("v%0d_final_q", idx), 32'(q), 32'(v.lim));
        step();
        check($sformatf("v%0d_done_pulse", idx), 32'(done), 32'd0);
    endtask

    vec_t vecs[6];
    int   k;
    logic [W-1:0] held;

    initial begin
        vecs[0] = '{load: 3'd2, lim: 3'd5, dn: 1'b0, done_edge: 5};
        vecs[1] = '{load: 3'd1, lim: 3'd6, dn: 1'b1, done_edge: 5};
        vecs[2] = '{load: 3'd4, lim: 3'd4, dn: 1'b0, done_edge: 2};
        vecs[3] = '{load: 3'd6, lim: 3'd1, dn: 1'b0, done_edge: 5};
        vecs[4] = '{load: 3'd0, lim: 3'd7, dn: 1'b1, done_edge: 3};
        vecs[5] = '{load: 3'd5, lim: 3'd2, dn: 1'b1, done_edge: 5};

        rst = 1'b1; start = 1'b1; dir = 1'b0; load_val = 3'd3; limit = 3'd6; tick = 1'b1;

        // Reset held two cycles with start asserted.
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_s", 32'(s), 32'd0);
            check("rst_r", 32'(r), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
            check("rst_err", 32'(err), 32'd0);
        end
        rst = 1'b0; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("idle_after_rst_busy", 32'(busy), 32'd0);
        end

        // Table-driven transactions.
        foreach (vecs[i]) run_vec(vecs[i], i);

        // Up count 2 -> 5: trajectory and excitation at q = 3.
        tick = 1'b1;
        kick(3'd2, 3'd5, 1'b0);
        step(); check("up_q_e1", 32'(q), 32'd2);
        step(); check("up_q_e2", 32'(q), 32'd3);
        check("up_s_at3", 32'(s), 32'b100);
        check("up_r_at3", 32'(r), 32'b011);
        step(); check("up_q_e3", 32'(q), 32'd4);
        step(); check("up_q_e4", 32'(q), 32'd5);
        check("up_busy_e4", 32'(busy), 32'd1);
        step(); check("up_done_e5", 32'(done), 32'd1);
        step();

        // Down count with wrap 1 -> 0 -> 7 -> 6.
        kick(3'd1, 3'd6, 1'b1);
        step(); check("dn_q_e1", 32'(q), 32'd1);
        step(); check("dn_q_e2", 32'(q), 32'd0);
        check("dn_s_at0", 32'(s), 32'b111);
        check("dn_r_at0", 32'(r), 32'b000);
        step(); check("dn_q_e3", 32'(q), 32'd7);
        step(); check("dn_q_e4", 32'(q), 32'd6);
        step(); check("dn_done_e5", 32'(done), 32'd1);
        step();

        // Tick gating with a stray start mid-run: done at edge 7.
        tick = 1'b1;
        kick(3'd0, 3'd3, 1'b0);
        step();                                  // edge 1, q = 0
        tick = 1'b1; step();                     // edge 2, q = 1
        tick = 1'b0; start = 1'b1;
        load_val = 3'd7; limit = 3'd7;
        #1;
        check("gate_s_e2", 32'(s), 32'd0);
        check("gate_r_e2", 32'(r), 32'd0);
        step();                                  // edge 3, stray start sampled
        start = 1'b0; tick = 1'b1;
        check("gate_hold_q_e3", 32'(q), 32'd1);
        step();                                  // edge 4, q = 2
        tick = 1'b0;
        #1;
        check("gate_s_e4", 32'(s), 32'd0);
        check("gate_r_e4", 32'(r), 32'd0);
        step();                                  // edge 5
        tick = 1'b1;
        step();                                  // edge 6, q = 3
        check("gate_q_e6", 32'(q), 32'd3);
        check("gate_done_e6", 32'(done), 32'd0);
        step();
        check("gate_done_e7", 32'(done), 32'd1);
        step();
        step();
        check("gate_no_queue_busy", 32'(busy), 32'd0);

        // load == limit: no excitation in RUN, done at edge 2.
        kick(3'd4, 3'd4, 1'b0);
        step();
        check("eq_s_e1", 32'(s), 32'd0);
        check("eq_r_e1", 32'(r), 32'd0);
        step();
        check("eq_done_e2", 32'(done), 32'd1);
        step();

        // Reset during the second RUN cycle.
        kick(3'd0, 3'd5, 1'b0);
        step();                                  // edge 1, q = 0
        step();                                  // edge 2, q = 1, drives T = 2
        rst = 1'b1;
        step();                                  // edge 3
        rst = 1'b0;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_s", 32'(s), 32'd0);
        check("mid_rst_r", 32'(r), 32'd0);
        held = q;
        check("mid_rst_q", 32'(held), 32'd2);
        k = 0;
        repeat (3) begin
            step();
            k++;
        end
        check("mid_rst_q_kept", 32'(q), 32'd2);
        check("mid_rst_stay_idle", 32'(busy), 32'd0);

`ifdef SR_COUNT_CTRL_VERIFY_EN
        // Bank bit 1 stuck at 0: 0 -> 1 -> (2 lost as 0) triggers err.
        stuck_zero = 3'b010;
        tick = 1'b1;
        kick(3'd0, 3'd3, 1'b0);
        step(); check("vf_q_e1", 32'(q), 32'd0);
        step(); check("vf_q_e2", 32'(q), 32'd1);
        step(); check("vf_q_e3", 32'(q), 32'd0);
        check("vf_err_e3", 32'(err), 32'd0);
        step();
        check("vf_done_e4", 32'(done), 32'd1);
        check("vf_err_e4", 32'(err), 32'd1);
        step(); step();
        check("vf_err_sticky", 32'(err), 32'd1);
        stuck_zero = 3'b000;
        kick(3'd0, 3'd0, 1'b0);
        check("vf_err_cleared", 32'(err), 32'd0);
        step(); step();
        check("vf_clean_done", 32'(done), 32'd1);
        check("vf_clean_err", 32'(err), 32'd0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
